jtsdram_scrambler: RTL and testbench

JTSDRAM_SCRAMBLER -- requirements
Module: jtsdram_scrambler

---
 rtl/jtsdram_scrambler.sv | 152 +++++++++++++++
 tb/tb_jtsdram_scrambler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsdram_scrambler.sv
// Keyed, invertible address/reference-data scrambler with a two-stage
// valid/ready pipeline. The key and direction are captured with each accepted beat.
module jtsdram_scrambler #(
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 16,
  parameter logic [4:0]  KEY_RST = 5'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_ld,
  input  logic [4:0]    key_din,
  input  logic          key_step,
  output logic [4:0]    key,
  input  logic          dir,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] ref_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] ref_out
);

  localparam int unsigned AH = AW / 2;
  localparam int unsigned DH = DW / 2;

  localparam logic [AW-1:0] ODD_A  = {AH{2'b01}};
  localparam logic [AW-1:0] EVEN_A = {AH{2'b10}};
  localparam logic [DW-1:0] ODD_D  = {DH{2'b01}};
  localparam logic [DW-1:0] EVEN_D = {DH{2'b10}};

  function automatic logic [3:0] swap4(input logic [3:0] n);
    return {n[2], n[0], n[3], n[1]};
  endfunction

  function automatic logic [3:0] unswap4(input logic [3:0] n);
    return {n[1], n[3], n[0], n[2]};
  endfunction

  // Forward steps in key-bit order; descramble replays them inverted, reversed.
  function automatic logic [AW-1:0] xf_addr(input logic [AW-1:0] v,
                                            input logic [4:0]    k,
                                            input logic          d);
    logic [AW-1:0] r;
    r = v;
    if (!d) begin
      if (k[0]) r = {r[AH-1:0], r[AW-1:AH]};
      if (k[1]) for (int i = 0; i < int'(AH / 4); i++) r[4*i +: 4] = swap4(r[4*i +: 4]);
      if (k[2]) for (int i = 0; i < int'(AH / 4); i++)
        r[int'(AH) + 4*i +: 4] = swap4(r[int'(AH) + 4*i +: 4]);
      if (k[3]) r = r ^ ODD_A;
      if (k[4]) r = r ^ EVEN_A;
    end else begin
      if (k[4]) r = r ^ EVEN_A;
      if (k[3]) r = r ^ ODD_A;
      if (k[2]) for (int i = 0; i < int'(AH / 4); i++)
        r[int'(AH) + 4*i +: 4] = unswap4(r[int'(AH) + 4*i +: 4]);
      if (k[1]) for (int i = 0; i < int'(AH / 4); i++) r[4*i +: 4] = unswap4(r[4*i +: 4]);
      if (k[0]) r = {r[AH-1:0], r[AW-1:AH]};
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] xf_ref(input logic [DW-1:0] v,
                                           input logic [4:0]    k,
                                           input logic          d);
    logic [DW-1:0] r;
    r = v;
    if (!d) begin
      if (k[0]) r = {r[DH-1:0], r[DW-1:DH]};
      if (k[1]) for (int i = 0; i < int'(DH / 4); i++) r[4*i +: 4] = swap4(r[4*i +: 4]);
      if (k[2]) for (int i = 0; i < int'(DH / 4); i++)
        r[int'(DH) + 4*i +: 4] = swap4(r[int'(DH) + 4*i +: 4]);
      if (k[3]) r = r ^ ODD_D;
      if (k[4]) r = r ^ EVEN_D;
    end else begin
      if (k[4]) r = r ^ EVEN_D;
      if (k[3]) r = r ^ ODD_D;
      if (k[2]) for (int i = 0; i < int'(DH / 4); i++)
        r[int'(DH) + 4*i +: 4] = unswap4(r[int'(DH) + 4*i +: 4]);
      if (k[1]) for (int i = 0; i < int'(DH / 4); i++) r[4*i +: 4] = unswap4(r[4*i +: 4]);
      if (k[0]) r = {r[DH-1:0], r[DW-1:DH]};
    end
    return r;
  endfunction

  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_ref;
  logic [4:0]    s1_key;
  logic          s1_dir;
  logic          s2_free;
  logic          accept;
  logic [AW-1:0] s1_xaddr;
  logic [DW-1:0] s1_xref;

  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_xaddr = xf_addr(s1_addr, s1_key, s1_dir);
    s1_xref  = xf_ref(s1_ref, s1_key, s1_dir);
  end

  // Key register: load beats step; beats accepted this cycle see the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      key <= KEY_RST;
    end else if (key_ld) begin
      key <= key_din;
    end else if (key_step) begin
      key <= key + 5'd1;
    end
  end

  // S1 captures the raw beat with its key/dir; holds while S2 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_ref   <= '0;
      s1_key   <= 5'd0;
      s1_dir   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_addr  <= addr_in;
      s1_ref   <= ref_in;
      s1_key   <= key;
      s1_dir   <= dir;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 holds the transformed beat and drives the outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      addr_out  <= '0;
      ref_out   <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        addr_out <= s1_xaddr;
        ref_out  <= s1_xref;
      end
    end
  end

endmodule

// File: tb/tb_jtsdram_scrambler.sv
// Bench for jtsdram_scrambler: bit-level reference model with a scoreboard
// checked every cycle, plus directed vectors with literal expectations.
module tb_jtsdram_scrambler;

  localparam logic [4:0] KRST = 5'd19;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_ld;
  logic [4:0]  key_din;
  logic        key_step;
  logic [4:0]  key;
  logic        dir;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] addr_in;
  logic [15:0] ref_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] addr_out;
  logic [15:0] ref_out;

  jtsdram_scrambler #(.AW(24), .DW(16), .KEY_RST(KRST)) dut (
    .clk(clk), .rst(rst), .key_ld(key_ld), .key_din(key_din), .key_step(key_step),
    .key(key), .dir(dir), .in_valid(in_valid), .in_ready(in_ready),
    .addr_in(addr_in), .ref_in(ref_in), .out_valid(out_valid), .out_ready(out_ready),
    .addr_out(addr_out), .ref_out(ref_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Rewrite nibbles in [lo,hi) so that out bit j = in bit t[j].
  function automatic logic [63:0] nib(input logic [63:0] v, input int lo, input int hi,
                                      input int t[4]);
    logic [63:0] x;
    logic [3:0]  n, o;
    x = v;
    for (int p = lo; p < hi; p += 4) begin
      n = x[p +: 4];
      for (int j = 0; j < 4; j++) o[j] = n[t[j]];
      x[p +: 4] = o;
    end
    return x;
  endfunction

  function automatic logic [63:0] mdl(input logic [63:0] v, input int w,
                                      input logic [4:0] k, input logic d);
    logic [63:0] m, x, p3, p4;
    int h;
    int fwd[4];
    int inv[4];
    fwd = '{1, 3, 0, 2};
    inv = '{2, 0, 3, 1};
    h = w / 2;
    m = (64'd1 << w) - 64'd1;
    x = v & m;
    p3 = '0;
    p4 = '0;
    for (int b = 0; b < w; b++) begin
      if (b % 2 == 0) p3[b] = 1'b1;
      else            p4[b] = 1'b1;
    end
    if (!d) begin
      if (k[0]) x = ((x << h) | (x >> h)) & m;
      if (k[1]) x = nib(x, 0, h, fwd);
      if (k[2]) x = nib(x, h, w, fwd);
      if (k[3]) x = x ^ p3;
      if (k[4]) x = x ^ p4;
    end else begin
      if (k[4]) x = x ^ p4;
      if (k[3]) x = x ^ p3;
      if (k[2]) x = nib(x, h, w, inv);
      if (k[1]) x = nib(x, 0, h, inv);
      if (k[0]) x = ((x >> h) | (x << (w - h))) & m;
    end
    return x;
  endfunction

  typedef struct {
    logic [23:0] a;
    logic [15:0] r;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  mkey = 5'd0;
  bit          armed = 1'b0;
  int unsigned cyc = 0;
  int          emitted = 0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_a;
  logic [15:0] prev_r;

  // Mid-cycle monitor: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
    if (armed) begin
      chk("key", 64'(key), 64'(mkey));
      chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) begin
        chk("addr_out", 64'(addr_out), 64'(q[0].a));
        chk("ref_out", 64'(ref_out), 64'(q[0].r));
      end
      if (prev_stall) begin
        chk("stall_addr", 64'(addr_out), 64'(prev_a));
        chk("stall_ref", 64'(ref_out), 64'(prev_r));
      end
    end
    prev_stall = armed && exp_ov && !out_ready && !rst;
    prev_a = addr_out;
    prev_r = ref_out;
    if (rst) begin
      q.delete();
      mkey  = KRST;
      armed = 1'b1;
    end else if (armed) begin
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        emitted++;
      end
      if (in_valid && in_ready)
        q.push_back('{a: 24'(mdl(64'(addr_in), 24, mkey, dir)),
                      r: 16'(mdl(64'(ref_in), 16, mkey, dir)), cyc: cyc});
      if (key_ld)        mkey = key_din;
      else if (key_step) mkey = mkey + 5'd1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setkey(input logic [4:0] k);
    key_ld  = 1'b1;
    key_din = k;
    tick();
    key_ld  = 1'b0;
  endtask

  task automatic send(input logic [23:0] a, input logic [15:0] r, input logic d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    addr_in  = a;
    ref_in   = r;
    dir      = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic recv(output logic [23:0] a, output logic [15:0] r);
    bit got;
    got = 1'b0;
    a = '0;
    r = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        a = addr_out;
        r = ref_out;
      end
    end
    tick();
    if (!got) chk("recv_timeout", 64'd0, 64'd1);
  endtask

  task automatic xfer(input logic [4:0] k, input logic [23:0] a, input logic [15:0] r,
                      input logic d, output logic [23:0] oa, output logic [15:0] orr);
    setkey(k);
    send(a, r, d);
    recv(oa, orr);
  endtask

  initial begin
    logic [23:0] oa, sa, ra;
    logic [15:0] orr, sr, rr;
    int          idx, base;
    bit          acc;

    rst = 1'b1; key_ld = 1'b0; key_din = '0; key_step = 1'b0; dir = 1'b0;
    in_valid = 1'b0; addr_in = '0; ref_in = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_key", 64'(key), 64'(KRST));
    chk("rst_addr_out", 64'(addr_out), 64'd0);
    chk("rst_ref_out", 64'(ref_out), 64'd0);

    // Directed literal vectors
    xfer(5'b00001, 24'h000001, 16'h1234, 1'b0, oa, orr);
    chk("swap_addr", 64'(oa), 64'h001000);
    chk("swap_ref", 64'(orr), 64'h3412);
    xfer(5'b00010, 24'h000000, 16'h0011, 1'b0, oa, orr);
    chk("nib_ref", 64'(orr), 64'h0044);
    chk("nib_addr", 64'(oa), 64'h000000);
    xfer(5'b01000, 24'h000000, 16'h1234, 1'b0, oa, orr);
    chk("xor5_ref", 64'(orr), 64'h4761);
    chk("xor5_addr", 64'(oa), 64'h555555);
    xfer(5'b10000, 24'h000000, 16'h0000, 1'b0, oa, orr);
    chk("xora_ref", 64'(orr), 64'haaaa);
    chk("xora_addr", 64'(oa), 64'haaaaaa);
    xfer(5'b00100, 24'h000000, 16'h1100, 1'b0, oa, orr);
    chk("nibhi_ref", 64'(orr), 64'h4400);

    // Round trip over all keys
    for (int k = 0; k < 32; k++) begin
      ra = 24'($urandom);
      rr = 16'($urandom);
      xfer(5'(k), ra, rr, 1'b0, sa, sr);
      xfer(5'(k), sa, sr, 1'b1, oa, orr);
      chk("rt_addr", 64'(oa), 64'(ra));
      chk("rt_ref", 64'(orr), 64'(rr));
    end

    // Backpressure: 8 beats, sink stalled for 5 cycles
    setkey(5'b10101);
    base = emitted;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      in_valid = 1'b1;
      addr_in  = 24'h100000 + 24'(idx * 24'h010203);
      ref_in   = 16'ha000 + 16'(idx);
      dir      = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 4) begin
        chk("bp_held", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      tick();
      if (acc) idx++;
      if (c == 4) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && emitted < base + 8; i++) tick();
    chk("bp_count", 64'(emitted - base), 64'd8);

    // Key wrap, load priority, old-key capture
    setkey(5'd31);
    key_step = 1'b1;
    tick();
    key_step = 1'b0;
    chk("key_wrap", 64'(key), 64'd0);
    setkey(5'd1);
    key_ld = 1'b1; key_din = 5'd7; key_step = 1'b1;
    in_valid = 1'b1; addr_in = 24'h000001; ref_in = 16'h1234; dir = 1'b0;
    tick();
    key_ld = 1'b0; key_step = 1'b0; in_valid = 1'b0;
    chk("key_ld_prio", 64'(key), 64'd7);
    recv(oa, orr);
    chk("oldkey_addr", 64'(oa), 64'h001000);
    chk("oldkey_ref", 64'(orr), 64'h3412);

    // Reset with two beats in flight
    setkey(5'd9);
    send(24'h0abcde, 16'h5a5a, 1'b0);
    send(24'h123456, 16'hbeef, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; addr_in = 24'h777777; ref_in = 16'h7777;
    tick();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_key", 64'(key), 64'(KRST));
    rst = 1'b0;
    in_valid = 1'b0;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
